button_counter_controller: RTL and testbench
============================================

# button_counter_controller

Command sequencer between the four-button debounced pulse vector and the 7-segment/LED display path. It owns the displayed count and the LED state. It latches button pulses as pending requests and services them one at a time in fixed priority. Each result is published to the display driver over a valid/ready handshake, so no pulse is lost while the driver is busy.

## Interface
Parameters:
- Count_Width, default 4: width of the count register.
- Count_Max, default 9: highest legal count; must satisfy 1 ≤ Count_Max ≤ 2^Count_Width − 1.

Ports:
- clk, input, 1: system clock.
- clk_en, input, 1: clock enable; all state holds when low.
- sync_rst, input, 1: reset; synchronous, active-high.
- button_pulse_vector, input, 4: one-cycle debounced pulses. [3] up, [2] down, [1] LED toggle, [0] clear.
- disp_valid, output, 1: display update offered.
- disp_ready, input, 1: display driver accepts the update.
- disp_count, output, Count_Width: count value of the offered update.
- disp_led, output, 1: LED state of the offered update.
- limit_hit, output, 1: one-cycle pulse when up/down reached a bound.
- dropped_pulse, output, 1: one-cycle pulse when a pulse merged into an already-pending request.
- busy, output, 1: high whenever state ≠ IDLE or any pending bit is set.

## Operation
- Internal registers: pending[3:0], count, led, state ∈ {INIT, IDLE, PUBLISH}. disp_count and disp_led are driven from count and led.
- **Capture:** on each enabled edge, pending[i] is set by button_pulse_vector[i].
  - If the same edge also clears pending[i] (service), the set wins and the new pulse is serviced later.
  - If pending[i] is already set and not being cleared, dropped_pulse pulses and the request merges.
- **INIT:** the state after reset. The next enabled edge moves to PUBLISH with the reset values (count 0, LED 0).
- **IDLE:** with any pending bit set, service exactly one request per edge in this priority order:
  - clear: count ← 0; LED unchanged; clear pending[0]; go to PUBLISH.
  - toggle: led ← ~led; clear pending[1]; go to PUBLISH.
  - up and down both pending: clear both, change nothing, stay IDLE (cancel).
  - up: count+1. At Count_Max, apply the boundary rule (see Configuration) and pulse limit_hit. Clear pending[3]; go to PUBLISH.
  - down: count−1. At 0, apply the boundary rule and pulse limit_hit. Clear pending[2]; go to PUBLISH.
- **PUBLISH:** disp_valid = 1. disp_count and disp_led stay stable until disp_valid && disp_ready on an enabled edge, then go to IDLE. No request is serviced in PUBLISH, but capture continues.
- **clk_en low:** pulses are ignored and nothing changes; outputs hold, and limit_hit and dropped_pulse stay in their current state.
- **sync_rst:** count 0, led 0, pending 0, state INIT, disp_valid 0, limit_hit 0, dropped_pulse 0. Reset has priority over all activity, including an in-flight handshake; the pending handshake is abandoned and the block republishes 0.

## Timing
- Pulse high in cycle c → pending set after edge c → serviced at edge c+1 → disp_valid high in cycle c+2.
- With disp_ready high, the handshake completes at edge c+2 and the block is IDLE in cycle c+3.
- Peak throughput is one published update per 2 enabled cycles.
- disp_valid is registered. Once high it never drops without a handshake, except on reset.
- limit_hit and dropped_pulse are registered, high for exactly one enabled cycle.
- After reset deassertion, the first disp_valid appears in the second enabled cycle.

## Configuration
- BUTTON_CTRL_WRAP_EN defined: up at Count_Max gives 0; down at 0 gives Count_Max.
- Undefined: saturate. Up at Count_Max stays at Count_Max; down at 0 stays at 0. An update is still published, and limit_hit still pulses in both modes.

## Test plan
- Reset, disp_ready=1: disp_valid high for exactly one cycle, with count 0 and LED 0. busy low afterwards.
- Ten up pulses spaced 4 cycles apart, Count_Max=9:
  - The final update shows 9 with wrap off, or 0 with wrap on.
  - limit_hit pulses exactly once.
- disp_ready held low for 20 cycles during an update:
  - disp_count and disp_valid stay stable.
  - Up, toggle and clear pulses arriving meanwhile are serviced in order clear, toggle, up after ready rises: published values 0 → LED flipped → 1.
- Up and down pulsed in the same cycle from count 5: no update is published, count stays 5, busy falls within 2 cycles.
- Two up pulses while up is already pending in PUBLISH: dropped_pulse pulses once for each, and only one increment results.
- sync_rst asserted while disp_valid is high and ready is low: disp_valid drops the next cycle, pending clears, and a count-0 update is republished.

Source files
------------

// File: rtl/button_counter_controller.sv
// Button command sequencer: latches debounced pulses, services one request per cycle in fixed
// priority and publishes count/LED over valid/ready. Define BUTTON_CTRL_WRAP_EN for wrap at bounds.
module button_counter_controller #(
    parameter int Count_Width = 4,
    parameter int Count_Max   = 9
) (
    input  logic                   clk,
    input  logic                   clk_en,
    input  logic                   sync_rst,
    input  logic [3:0]             button_pulse_vector,
    output logic                   disp_valid,
    input  logic                   disp_ready,
    output logic [Count_Width-1:0] disp_count,
    output logic                   disp_led,
    output logic                   limit_hit,
    output logic                   dropped_pulse,
    output logic                   busy
);

    localparam logic [Count_Width-1:0] MAX_VAL  = Count_Width'(Count_Max);
    localparam logic [Count_Width-1:0] ONE_VAL  = Count_Width'(1);
    localparam int                     BTN_UP     = 3;
    localparam int                     BTN_DOWN   = 2;
    localparam int                     BTN_TOGGLE = 1;
    localparam int                     BTN_CLEAR  = 0;
`ifdef BUTTON_CTRL_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             pending_q, pending_d;
    logic [Count_Width-1:0] count_q, count_d;
    logic                   led_q, led_d;
    logic                   limit_hit_q, limit_hit_d;
    logic                   dropped_q, dropped_d;
    logic [3:0]             service_clr;

    // Handshake: disp_valid, disp_count and disp_led are held from the cycle disp_valid rises
    // until an enabled edge sees disp_valid && disp_ready; only reset may abandon an offer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        led_d       = led_q;
        limit_hit_d = 1'b0;
        service_clr = 4'b0000;
        case (state_q)
            ST_INIT: state_d = ST_PUBLISH;
            ST_IDLE: begin
                if (pending_q[BTN_CLEAR]) begin
                    count_d                = '0;
                    service_clr[BTN_CLEAR] = 1'b1;
                    state_d                = ST_PUBLISH;
                end else if (pending_q[BTN_TOGGLE]) begin
                    led_d                   = ~led_q;
                    service_clr[BTN_TOGGLE] = 1'b1;
                    state_d                 = ST_PUBLISH;
                end else if (pending_q[BTN_UP] && pending_q[BTN_DOWN]) begin
                    // Opposing requests cancel: nothing changes and nothing is published.
                    service_clr[BTN_UP]   = 1'b1;
                    service_clr[BTN_DOWN] = 1'b1;
                end else if (pending_q[BTN_UP]) begin
                    service_clr[BTN_UP] = 1'b1;
                    state_d             = ST_PUBLISH;
                    if (count_q == MAX_VAL) begin
                        limit_hit_d = 1'b1;
                        count_d     = WRAP_EN ? '0 : MAX_VAL;
                    end else begin
                        count_d = count_q + ONE_VAL;
                    end
                end else if (pending_q[BTN_DOWN]) begin
                    service_clr[BTN_DOWN] = 1'b1;
                    state_d               = ST_PUBLISH;
                    if (count_q == '0) begin
                        limit_hit_d = 1'b1;
                        count_d     = WRAP_EN ? MAX_VAL : '0;
                    end else begin
                        count_d = count_q - ONE_VAL;
                    end
                end
            end
            ST_PUBLISH: begin
                if (disp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // A new pulse on the edge that services the same request survives as a fresh request.
        pending_d = (pending_q & ~service_clr) | button_pulse_vector;
        dropped_d = |(pending_q & ~service_clr & button_pulse_vector);
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q     <= ST_INIT;
            pending_q   <= 4'b0000;
            count_q     <= '0;
            led_q       <= 1'b0;
            limit_hit_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            count_q     <= count_d;
            led_q       <= led_d;
            limit_hit_q <= limit_hit_d;
            dropped_q   <= dropped_d;
        end
    end

    assign disp_valid    = (state_q == ST_PUBLISH);
    assign disp_count    = count_q;
    assign disp_led      = led_q;
    assign limit_hit     = limit_hit_q;
    assign dropped_pulse = dropped_q;
    assign busy          = (state_q != ST_IDLE) || (|pending_q);

endmodule

// File: tb/tb_button_counter_controller.sv
// Bench for button_counter_controller: directed scenarios plus randomized traffic, all checked
// against a request-list model of the command rules. Honours BUTTON_CTRL_WRAP_EN.
`timescale 1ns/1ps
module tb_button_counter_controller;

    localparam int CW   = 4;
    localparam int CMAX = 9;
`ifdef BUTTON_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          clk_en;
    logic          sync_rst;
    logic [3:0]    btn;
    logic          disp_valid;
    logic          disp_ready;
    logic [CW-1:0] disp_count;
    logic          disp_led;
    logic          limit_hit;
    logic          dropped_pulse;
    logic          busy;

    always #5 clk = ~clk;

    button_counter_controller #(.Count_Width(CW), .Count_Max(CMAX)) dut (
        .clk                 (clk),
        .clk_en              (clk_en),
        .sync_rst            (sync_rst),
        .button_pulse_vector (btn),
        .disp_valid          (disp_valid),
        .disp_ready          (disp_ready),
        .disp_count          (disp_count),
        .disp_led            (disp_led),
        .limit_hit           (limit_hit),
        .dropped_pulse       (dropped_pulse),
        .busy                (busy)
    );

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Requests are a list of flags; "offering" means an update is on the display bus.
    int           m_count;
    bit           m_led;
    bit           m_req[4];
    bit           m_fresh;
    bit           m_offer;
    bit           m_lim;
    bit           m_drop;
    logic [CW:0]  exp_q[$];

    function automatic logic [CW:0] upd(input bit led, input int cnt);
        return {led, CW'(cnt)};
    endfunction

    task automatic m_publish();
        m_offer = 1'b1;
        exp_q.push_back(upd(m_led, m_count));
    endtask

    task automatic model_step(input logic [3:0] b, input logic rdy, input logic en, input logic rst);
        bit clr[4];
        if (rst) begin
            m_count = 0;
            m_led   = 1'b0;
            m_req   = '{default: 1'b0};
            m_fresh = 1'b1;
            m_offer = 1'b0;
            m_lim   = 1'b0;
            m_drop  = 1'b0;
            exp_q.delete();
        end else if (en) begin
            clr   = '{default: 1'b0};
            m_lim = 1'b0;
            if (m_fresh) begin
                m_fresh = 1'b0;
                m_publish();
            end else if (m_offer) begin
                if (rdy) begin
                    m_offer = 1'b0;
                    void'(exp_q.pop_front());
                end
            end else if (m_req[0]) begin
                clr[0]  = 1'b1;
                m_count = 0;
                m_publish();
            end else if (m_req[1]) begin
                clr[1] = 1'b1;
                m_led  = ~m_led;
                m_publish();
            end else if (m_req[3] && m_req[2]) begin
                clr[3] = 1'b1;
                clr[2] = 1'b1;
            end else if (m_req[3]) begin
                clr[3] = 1'b1;
                m_lim  = (m_count == CMAX);
                if (WRAP) m_count = (m_count + 1) % (CMAX + 1);
                else      m_count = (m_count + 1 > CMAX) ? CMAX : m_count + 1;
                m_publish();
            end else if (m_req[2]) begin
                clr[2] = 1'b1;
                m_lim  = (m_count == 0);
                if (WRAP) m_count = (m_count + CMAX) % (CMAX + 1);
                else      m_count = (m_count == 0) ? 0 : m_count - 1;
                m_publish();
            end
            m_drop = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (b[i]) begin
                    if (m_req[i] && !clr[i]) m_drop = 1'b1;
                    m_req[i] = 1'b1;
                end else if (clr[i]) begin
                    m_req[i] = 1'b0;
                end
            end
        end
    endtask

    function automatic bit m_busy();
        bit any;
        any = m_req[0] | m_req[1] | m_req[2] | m_req[3];
        return m_fresh || m_offer || any;
    endfunction

    // ---------------- observation log ----------------
    int          pub_cnt, lim_cnt, drop_cnt, valid_cnt;
    logic [CW:0] pub_log[$];

    task automatic clear_obs();
        pub_cnt   = 0;
        lim_cnt   = 0;
        drop_cnt  = 0;
        valid_cnt = 0;
        pub_log.delete();
    endtask

    function automatic logic [CW:0] pub_at(input int k);
        if (k >= 0 && k < pub_log.size()) return pub_log[k];
        return '1;
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        logic        en_at_edge;
        logic [CW:0] head;
        en_at_edge = clk_en;
        if (!sync_rst && clk_en && disp_ready && disp_valid === 1'b1) begin
            pub_cnt++;
            pub_log.push_back({disp_led, disp_count});
        end
        model_step(btn, disp_ready, clk_en, sync_rst);
        @(posedge clk);
        #1;
        check("disp_valid", disp_valid, m_offer);
        check("busy", busy, m_busy());
        check("limit_hit", limit_hit, m_lim);
        check("dropped_pulse", dropped_pulse, m_drop);
        if (m_offer && exp_q.size() > 0) begin
            head = exp_q[0];
            check("disp_count", disp_count, head[CW-1:0]);
            check("disp_led", disp_led, head[CW]);
        end
        if (en_at_edge) begin
            if (limit_hit === 1'b1)     lim_cnt++;
            if (dropped_pulse === 1'b1) drop_cnt++;
            if (disp_valid === 1'b1)    valid_cnt++;
        end
        btn = 4'b0000;
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [3:0] b);
        btn = b;
        tick();
    endtask

    task automatic do_reset();
        sync_rst = 1'b1;
        tick();
        tick();
        sync_rst = 1'b0;
    endtask

    task automatic reset_and_settle();
        disp_ready = 1'b1;
        clk_en     = 1'b1;
        do_reset();
        idle_n(4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clk_en     = 1'b1;
        sync_rst   = 1'b1;
        btn        = 4'b0000;
        disp_ready = 1'b1;
        clear_obs();

        // Reset with ready high: one 0/0 update, then quiet.
        do_reset();
        clear_obs();
        idle_n(6);
        check("rst_valid_cycles", valid_cnt, 1);
        check("rst_pub_cnt", pub_cnt, 1);
        check("rst_pub_value", pub_at(0), upd(1'b0, 0));
        check("rst_busy_after", busy, 0);

        // Ten up pulses spaced four cycles apart.
        clear_obs();
        repeat (10) begin
            pulse(4'b1000);
            idle_n(3);
        end
        check("up10_pub_cnt", pub_cnt, 10);
        check("up10_ninth", pub_at(8), upd(1'b0, 9));
        check("up10_last", pub_at(9), upd(1'b0, WRAP ? 0 : CMAX));
        check("up10_limit_cnt", lim_cnt, 1);

        // Back-pressure for 20 cycles while up, toggle and clear arrive.
        reset_and_settle();
        clear_obs();
        disp_ready = 1'b0;
        pulse(4'b1000);
        idle_n(1);
        for (int k = 0; k < 20; k++) begin
            btn = (k == 3) ? 4'b1000 : (k == 8) ? 4'b0010 : (k == 13) ? 4'b0001 : 4'b0000;
            tick();
            check("hold_valid", disp_valid, 1);
            check("hold_count", disp_count, 1);
        end
        disp_ready = 1'b1;
        idle_n(10);
        check("bp_pub_cnt", pub_cnt, 4);
        check("bp_pub0", pub_at(0), upd(1'b0, 1));
        check("bp_pub_clear", pub_at(1), upd(1'b0, 0));
        check("bp_pub_toggle", pub_at(2), upd(1'b1, 0));
        check("bp_pub_up", pub_at(3), upd(1'b1, 1));

        // Up and down together from count 5 cancel.
        reset_and_settle();
        repeat (5) begin
            pulse(4'b1000);
            idle_n(3);
        end
        clear_obs();
        pulse(4'b1100);
        check("cancel_busy_pending", busy, 1);
        tick();
        check("cancel_busy_fall", busy, 0);
        idle_n(6);
        check("cancel_no_pub", pub_cnt, 0);
        pulse(4'b1000);
        idle_n(3);
        check("cancel_count_kept", pub_at(0), upd(1'b0, 6));

        // Extra up pulses merge into a pending up while publishing.
        reset_and_settle();
        disp_ready = 1'b0;
        pulse(4'b1000);
        idle_n(1);
        clear_obs();
        pulse(4'b1000);
        idle_n(1);
        pulse(4'b1000);
        idle_n(1);
        pulse(4'b1000);
        idle_n(2);
        check("merge_drop_cnt", drop_cnt, 2);
        disp_ready = 1'b1;
        idle_n(8);
        check("merge_pub_cnt", pub_cnt, 2);
        check("merge_pub_last", pub_at(1), upd(1'b0, 2));

        // Reset during a stalled offer abandons it and republishes zero.
        reset_and_settle();
        disp_ready = 1'b0;
        pulse(4'b1000);
        idle_n(1);
        pulse(4'b0010);
        sync_rst = 1'b1;
        tick();
        check("rst_mid_valid", disp_valid, 0);
        sync_rst   = 1'b0;
        disp_ready = 1'b1;
        clear_obs();
        idle_n(6);
        check("rst_mid_pub_cnt", pub_cnt, 1);
        check("rst_mid_pub_value", pub_at(0), upd(1'b0, 0));

        // Clock enable low freezes everything, including the one-cycle pulses.
        reset_and_settle();
        disp_ready = 1'b0;
        pulse(4'b1000);
        idle_n(1);
        clk_en = 1'b0;
        pulse(4'b0001);
        idle_n(3);
        check("en_hold_valid", disp_valid, 1);
        check("en_hold_count", disp_count, 1);
        clk_en     = 1'b1;
        disp_ready = 1'b1;
        idle_n(4);
        check("en_pulse_ignored", busy, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            btn[3]     = ($urandom_range(0, 5) == 0);
            btn[2]     = ($urandom_range(0, 6) == 0);
            btn[1]     = ($urandom_range(0, 9) == 0);
            btn[0]     = ($urandom_range(0, 40) == 0);
            disp_ready = ($urandom_range(0, 3) != 0);
            clk_en     = ($urandom_range(0, 7) != 0);
            sync_rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        sync_rst = 1'b0;
        clk_en   = 1'b1;
        idle_n(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
